// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player memory-game turn FSM (pick, check, show, swap, done).
// Pulses are registered; a pending flag issues timer_restart one cycle after a match or reset release.
module turn_sequencer #(
    parameter int SHOW_CYCLES = 4,
    parameter int NUM_PAIRS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       select,
    input  logic [3:0] cursor,
    input  logic [3:0] card_label,
    input  logic       card_avail,
    input  logic       time_up,
    output logic       reveal_en,
    output logic [3:0] reveal_idx,
    output logic       hide_en,
    output logic       claim_en,
    output logic [3:0] sel1,
    output logic [3:0] sel2,
    output logic       player,
    output logic       timer_restart,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        PICK1 = 3'd0, PICK2 = 3'd1, CHECK = 3'd2, SHOW = 3'd3, SWAP = 3'd4, DONE = 3'd5
    } state_t;

    state_t     cur, nxt;
    logic [3:0] label1, label2, label1_n, label2_n, sel1_n, sel2_n;
    logic [3:0] score0_n, score1_n, pairs, pairs_n, reveal_idx_n;
    logic [7:0] cnt, cnt_n;
    logic       player_n, pend, pend_n, reveal_n, hide_n, claim_n, restart_n;

    always_comb begin
        nxt          = cur;
        sel1_n       = sel1;
        sel2_n       = sel2;
        label1_n     = label1;
        label2_n     = label2;
        score0_n     = score0;
        score1_n     = score1;
        pairs_n      = pairs;
        cnt_n        = cnt;
        player_n     = player;
        reveal_idx_n = reveal_idx;
        pend_n       = 1'b0;
        reveal_n     = 1'b0;
        hide_n       = 1'b0;
        claim_n      = 1'b0;
        restart_n    = 1'b0;
        // A pending restart owns its cycle so the pulses never overlap
        if (pend) begin
            restart_n = 1'b1;
        end else begin
            case (cur)
                PICK1: begin
                    if (time_up) begin
                        nxt = SWAP;
                    end else if (select && card_avail) begin
                        sel1_n       = cursor;
                        label1_n     = card_label;
                        reveal_n     = 1'b1;
                        reveal_idx_n = cursor;
                        nxt          = PICK2;
                    end
                end
                PICK2: begin
                    if (time_up) begin
                        sel2_n = sel1;
                        hide_n = 1'b1;
                        nxt    = SWAP;
                    end else if (select && card_avail && cursor != sel1) begin
                        sel2_n       = cursor;
                        label2_n     = card_label;
                        reveal_n     = 1'b1;
                        reveal_idx_n = cursor;
                        nxt          = CHECK;
                    end
                end
                CHECK: begin
                    if (label1 == label2) begin
                        claim_n  = 1'b1;
                        pend_n   = 1'b1;
                        pairs_n  = pairs + 4'd1;
                        score0_n = player ? score0 : score0 + 4'd1;
                        score1_n = player ? score1 + 4'd1 : score1;
                        nxt      = (pairs_n == 4'(NUM_PAIRS)) ? DONE : PICK1;
                    end else begin
                        cnt_n = 8'(SHOW_CYCLES);
                        nxt   = SHOW;
                    end
                end
                SHOW: begin
                    cnt_n  = (cnt <= 8'd1) ? 8'd0 : cnt - 8'd1;
                    hide_n = (cnt <= 8'd1);
                    nxt    = (cnt <= 8'd1) ? SWAP : SHOW;
                end
                SWAP: begin
                    player_n  = ~player;
                    restart_n = 1'b1;
                    nxt       = PICK1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur           <= PICK1;
            player        <= 1'b0;
            sel1          <= '0;
            sel2          <= '0;
            label1        <= '0;
            label2        <= '0;
            score0        <= '0;
            score1        <= '0;
            pairs         <= '0;
            cnt           <= '0;
            pend          <= 1'b1;
            reveal_en     <= 1'b0;
            reveal_idx    <= '0;
            hide_en       <= 1'b0;
            claim_en      <= 1'b0;
            timer_restart <= 1'b0;
        end else begin
            cur           <= nxt;
            player        <= player_n;
            sel1          <= sel1_n;
            sel2          <= sel2_n;
            label1        <= label1_n;
            label2        <= label2_n;
            score0        <= score0_n;
            score1        <= score1_n;
            pairs         <= pairs_n;
            cnt           <= cnt_n;
            pend          <= pend_n;
            reveal_en     <= reveal_n;
            reveal_idx    <= reveal_idx_n;
            hide_en       <= hide_n;
            claim_en      <= claim_n;
            timer_restart <= restart_n;
        end
    end

    assign state     = cur;
    assign game_over = (cur == DONE);
    assign winner    = !game_over ? 2'b00 : (score0 > score1) ? 2'b01 :
                       (score1 > score0) ? 2'b10 : 2'b11;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: random turns on a shuffled board checked against a turn-level game model.
module tb_turn_sequencer;
    localparam int SHOW = 4;
    localparam int NP   = 8;

    logic       clk = 1'b0, rst = 1'b1, select = 1'b0, card_avail = 1'b0, time_up = 1'b0;
    logic [3:0] cursor = '0, card_label = '0;
    logic       reveal_en, hide_en, claim_en, player, timer_restart, game_over;
    logic [3:0] reveal_idx, sel1, sel2, score0, score1;
    logic [1:0] winner;
    logic [2:0] state;

    turn_sequencer #(.SHOW_CYCLES(SHOW), .NUM_PAIRS(NP)) dut (
        .clk(clk), .rst(rst), .select(select), .cursor(cursor), .card_label(card_label),
        .card_avail(card_avail), .time_up(time_up), .reveal_en(reveal_en),
        .reveal_idx(reveal_idx), .hide_en(hide_en), .claim_en(claim_en), .sel1(sel1),
        .sel2(sel2), .player(player), .timer_restart(timer_restart), .score0(score0),
        .score1(score1), .game_over(game_over), .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int c_rev = 0, c_hide = 0, c_claim = 0, c_rst = 0, overlap = 0, show_run = 0, show_len = 0;
    int rev_idx = 0, hide_s1 = 0, hide_s2 = 0;
    int m_rev = 0, m_hide = 0, m_claim = 0, m_rst = 0, m_player = 0, m_s0 = 0, m_s1 = 0, m_pairs = 0;
    int labels[16];
    bit claimed[16];
    bit last_match = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reveal_en) begin c_rev++; rev_idx = int'(reveal_idx); end
        if (hide_en) begin c_hide++; hide_s1 = int'(sel1); hide_s2 = int'(sel2); end
        if (claim_en) c_claim++;
        if (timer_restart) c_rst++;
        if (int'(reveal_en) + int'(hide_en) + int'(claim_en) + int'(timer_restart) > 1) overlap++;
        if (state == 3'd3) show_run++;
        else if (show_run > 0) begin show_len = show_run; show_run = 0; end
    end

    task automatic new_board();
        int j, t;
        for (int i = 0; i < 16; i++) begin labels[i] = i / 2; claimed[i] = 0; end
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = labels[i]; labels[i] = labels[j]; labels[j] = t;
        end
        m_player = 0; m_s0 = 0; m_s1 = 0; m_pairs = 0; last_match = 0;
    endtask

    task automatic cyc(input bit s, input int c, input bit a, input bit t);
        @(posedge clk); #2;
        select = s; cursor = 4'(c); card_label = 4'(labels[c]); card_avail = a; time_up = t;
        @(posedge clk); #2;
        select = 0; card_avail = 0; time_up = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic settle();
        int k = 0;
        while (!(state == 3'd0 || state == 3'd5) && k < 60) begin @(negedge clk); k++; end
        if (k >= 60) chk("settle_timeout", k, 0);
        idle(3);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_reveals"}, c_rev, m_rev);
        chk({tag, "_hides"}, c_hide, m_hide);
        chk({tag, "_claims"}, c_claim, m_claim);
        chk({tag, "_restarts"}, c_rst, m_rst);
        chk({tag, "_score0"}, int'(score0), m_s0);
        chk({tag, "_score1"}, int'(score1), m_s1);
        chk({tag, "_player"}, int'(player), m_player);
        chk({tag, "_overlap"}, overlap, 0);
    endtask

    function automatic int any_unclaimed();
        int i;
        do i = $urandom_range(0, 15); while (claimed[i]);
        return i;
    endfunction

    function automatic int partner(input int a);
        for (int j = 0; j < 16; j++) if (j != a && labels[j] == labels[a]) return j;
        return a;
    endfunction

    function automatic int other(input int a);
        int c[$];
        for (int j = 0; j < 16; j++) if (!claimed[j] && labels[j] != labels[a]) c.push_back(j);
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    task automatic turn(input int mode);
        int a, b, r;
        r = (mode == 1) ? (last_match ? 0 : 9) : $urandom_range(0, 9);
        if (r == 0) begin
            cyc(1, any_unclaimed(), 1, 1);
            m_player ^= 1; m_rst++; last_match = 0;
            settle(); check_all("tu_pick1");
            return;
        end
        a = any_unclaimed();
        if ($urandom_range(0, 3) == 0) begin
            cyc(1, a, 0, 0); idle(1);
            chk("unavail_ignored", c_rev, m_rev);
        end
        cyc(1, a, 1, 0); m_rev++; idle(1);
        chk("reveal_idx1", rev_idx, a);
        chk("sel1", int'(sel1), a);
        chk("in_pick2", int'(state), 1);
        if (mode == 0 && $urandom_range(0, 2) == 0) begin
            cyc(1, a, 1, 0); idle(1);
            chk("repeat_reveal", c_rev, m_rev);
            chk("repeat_state", int'(state), 1);
        end
        if (r == 1) begin
            cyc(0, 0, 0, 1);
            m_hide++; m_rst++; m_player ^= 1; last_match = 0;
            settle();
            chk("tu_hide_s1", hide_s1, a);
            chk("tu_hide_s2", hide_s2, a);
            check_all("tu_pick2");
            return;
        end
        b = (r >= 6) ? partner(a) : other(a);
        if (b < 0) b = partner(a);
        cyc(1, b, 1, 0); m_rev++;
        if (labels[a] == labels[b]) begin
            m_claim++; m_rst++; m_pairs++; claimed[a] = 1; claimed[b] = 1; last_match = 1;
            if (m_player == 1) m_s1++; else m_s0++;
            settle(); check_all("match");
        end else begin
            m_hide++; m_rst++; m_player ^= 1; last_match = 0;
            settle();
            chk("show_len", show_len, SHOW);
            chk("mm_hide_s1", hide_s1, a);
            chk("mm_hide_s2", hide_s2, b);
            check_all("mismatch");
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst = 1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_player", int'(player), 0);
        chk("rst_sel", int'({sel1, sel2}), 0);
        chk("rst_scores", int'({score0, score1}), 0);
        chk("rst_done", int'({game_over, winner}), 0);
        chk("rst_pulses", int'({reveal_en, hide_en, claim_en, timer_restart}), 0);
        new_board();
        @(negedge clk); rst = 0;
        m_rst++;
        idle(3);
        check_all("after_rst");
    endtask

    task automatic play(input int mode);
        int turns = 0, w;
        while (m_pairs < NP && turns < 300) begin turn(mode); turns++; end
        w = (m_s0 > m_s1) ? 1 : (m_s1 > m_s0) ? 2 : 3;
        chk("game_over", int'(game_over), 1);
        chk("winner", int'(winner), w);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        idle(3);
        chk("done_state", int'(state), 5);
        check_all("done_frozen");
    endtask

    initial begin
        int a, b, k;
        new_board();
        #12;
        chk("init_state", int'(state), 0);
        chk("init_pulses", int'({reveal_en, hide_en, claim_en, timer_restart}), 0);
        chk("init_winner", int'(winner), 0);
        @(negedge clk); rst = 0;
        m_rst = 1;
        idle(3);
        check_all("release");
        play(1);
        chk("tie_winner", int'(winner), 3);
        do_reset();
        play(0);
        do_reset();
        play(0);
        do_reset();
        a = any_unclaimed();
        b = other(a);
        cyc(1, a, 1, 0);
        cyc(1, b, 1, 0);
        m_rev += 2;
        k = 0;
        while (state != 3'd3 && k < 20) begin @(negedge clk); k++; end
        chk("reach_show", int'(state), 3);
        do_reset();
        chk("show_rst_hides", c_hide, m_hide);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 The block SHALL have parameter SHOW_CYCLES, default 4: cycles a mismatched pair stays face-up before hiding, legal range 1..255.
REQ-002 The block SHALL have parameter NUM_PAIRS, default 8: pairs on the 16-card board.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port select, input, 1 bit: one-cycle pulse to pick the card at cursor.
REQ-006 The block SHALL have port cursor, input, 4 bits: board index 0..15 currently pointed at.
REQ-007 The block SHALL have port card_label, input, 4 bits: label of the card at cursor.
REQ-008 The block SHALL have port card_avail, input, 1 bit: card at cursor is face-down and unclaimed.
REQ-009 The block SHALL have port time_up, input, 1 bit: one-cycle pulse when the turn timer expires.
REQ-010 The block SHALL have port reveal_en, output, 1 bit: one-cycle pulse to flip the card at reveal_idx face-up.
REQ-011 The block SHALL have port reveal_idx, output, 4 bits: index to reveal.
REQ-012 The block SHALL have port hide_en, output, 1 bit: one-cycle pulse to flip cards sel1 and sel2 face-down.
REQ-013 The block SHALL have port claim_en, output, 1 bit: one-cycle pulse marking sel1 and sel2 as owned by player.
REQ-014 The block SHALL have ports sel1 and sel2, outputs, 4 bits each: latched first and second picks.
REQ-015 The block SHALL have port player, output, 1 bit: player on turn (0 or 1).
REQ-016 The block SHALL have port timer_restart, output, 1 bit: one-cycle pulse to restart the turn timer.
REQ-017 The block SHALL have ports score0 and score1, outputs, 4 bits each: pairs claimed per player.
REQ-018 The block SHALL have port game_over, output, 1 bit: all pairs claimed.
REQ-019 The block SHALL have port winner, output, 2 bits: 00 none, 01 player0, 10 player1, 11 tie.
REQ-020 The block SHALL have port state, output, 3 bits: FSM state code.

Function
REQ-021 FSM states and codes SHALL be PICK1=0, PICK2=1, CHECK=2, SHOW=3, SWAP=4, DONE=5.
REQ-022 PICK1: select with card_avail=1 SHALL latch sel1=cursor and label1=card_label, pulse reveal_en with reveal_idx=cursor, and go to PICK2; select with card_avail=0 SHALL be ignored.
REQ-023 PICK2: select with card_avail=1 and cursor!=sel1 SHALL latch sel2 and label2, pulse reveal_en, and go to CHECK; any other select SHALL be ignored.
REQ-024 CHECK (exactly 1 cycle), label1==label2: SHALL pulse claim_en, increment the current player's score, increment the internal pair count, and pulse timer_restart; the same player keeps the turn.
REQ-025 CHECK, match: go to DONE if the pair count reaches NUM_PAIRS, else go to PICK1.
REQ-026 CHECK, labels differ: SHALL load the show counter with SHOW_CYCLES and go to SHOW.
REQ-027 SHOW: counter decrements each cycle; at zero SHALL pulse hide_en and go to SWAP; time_up and select SHALL be ignored in SHOW.
REQ-028 time_up in PICK1 SHALL go to SWAP with no reveal or hide.
REQ-029 time_up in PICK2 SHALL set sel2=sel1, pulse hide_en, and go to SWAP.
REQ-030 If time_up and select arrive in the same cycle, time_up SHALL take priority.
REQ-031 SWAP (1 cycle): SHALL toggle player, pulse timer_restart, and go to PICK1.
REQ-032 DONE: game_over=1; winner set by comparing score0 and score1; all inputs ignored until rst.
REQ-033 Scores SHALL never exceed NUM_PAIRS, so no wrap-around; score0+score1 SHALL equal the pair count at all times.
REQ-034 reveal_en, hide_en, claim_en and timer_restart SHALL be registered, one cycle wide, and mutually exclusive.

Reset
REQ-035 When rst=1, the block SHALL immediately set state=PICK1, player=0, sel1=sel2=0, scores=0, pair count=0, show counter=0, game_over=0, winner=00, and all pulses 0.
REQ-036 Reset asserted mid-turn (including during SHOW) SHALL abandon the turn without emitting hide_en.
REQ-037 On the first clock edge after rst falls, the block SHALL pulse timer_restart once.

Verification
REQ-038 Match: pick idx 0 then idx 13 (label 1 for both) -> claim_en one cycle after CHECK entry, score0=1, player stays 0, state=PICK1.
REQ-039 Mismatch: pick idx 0 (label 1) then idx 1 (label 3) -> SHOW for 4 cycles, then hide_en with sel1=0 and sel2=1, then SWAP, then player=1.
REQ-040 Repeat pick: in PICK2, select with cursor==sel1 -> no reveal_en, state stays PICK2; select with card_avail=0 -> ignored.
REQ-041 Timeout: time_up in PICK2 after picking idx 5 -> hide_en with sel1=sel2=5, player toggles; time_up and select in the same cycle in PICK1 -> no reveal_en, SWAP.
REQ-042 Full game: 8 matches split 4/4 -> game_over=1, winner=11; further select has no effect; rst clears all.
REQ-043 Reset asserted during SHOW -> outputs cleared asynchronously, no hide_en emitted, timer_restart pulses after release.
